// File: rtl/shufflev_rng_scheduler.sv
// shufflev_rng_scheduler
//   Owns the shufflev RNG: strobes its seed load once after reset, then shares
//   its 32-bit output among NumReq requesters in round-robin order. Each grant
//   returns a value uniform in [0, bound] using masked rejection sampling. After
//   MaxRetry rejected samples, it falls back deterministically to cand >> 1.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   rng_load_seed_o  one-cycle seed-load strobe to the RNG
//   rng_number_i     RNG output word
//   rng_valid_i      rng_number_i is fresh this cycle
//   req_i            per-requester request level, held until acked
//   bound_i          packed inclusive bounds, slice i belongs to requester i
//   req_ack_o        one-hot grant pulse; bound has been captured
//   rsp_valid_o      one-hot result-valid for the granted requester
//   rsp_number_o     shared result bus
//   rsp_ready_i      per-requester result accept; only the granted bit matters
//   ready_o          seeding finished, requests are being accepted
module shufflev_rng_scheduler #(
  parameter int NumReq   = 2,
  parameter int BoundW   = 8,
  parameter int MaxRetry = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  output logic                     rng_load_seed_o,
  input  logic [31:0]              rng_number_i,
  input  logic                     rng_valid_i,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq*BoundW-1:0] bound_i,
  output logic [NumReq-1:0]        req_ack_o,
  output logic [NumReq-1:0]        rsp_valid_o,
  output logic [BoundW-1:0]        rsp_number_o,
  input  logic [NumReq-1:0]        rsp_ready_i,
  output logic                     ready_o
);

  localparam int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int RetryW = (MaxRetry > 0) ? $clog2(MaxRetry + 1) : 1;
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MaxRetry);
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(NumReq - 1);

  typedef enum logic [2:0] {
    SEED,
    LOAD,
    IDLE,
    SAMPLE,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic                seed_q;
  logic [NumReq-1:0]   ack_q;
  logic [BoundW-1:0]   bound_q;
  logic [IdxW-1:0]     idx_q;
  logic [IdxW-1:0]     rr_q;
  logic [RetryW-1:0]   retry_q;
  logic [BoundW-1:0]   rsp_number_q;

  logic                pick_valid;
  logic                pick_hi;
  logic [IdxW-1:0]     pick_idx;
  logic [BoundW-1:0]   pick_bound;
  logic [BoundW-1:0]   mask;
  logic [BoundW-1:0]   cand;
  logic                accept;
  logic                exhausted;
  logic [IdxW-1:0]     rr_next;

  // The upper RNG bits are intentionally discarded.
  if (BoundW < 32) begin : g_unused
    logic unused_rng_hi;
    assign unused_rng_hi = ^rng_number_i[31:BoundW];
  end

  // Round-robin pick. The first pass finds the lowest set bit overall, which
  // is the wrap-around choice. The second pass overrides it with the lowest
  // set bit at or above the pointer, when such a bit exists.
  always_comb begin
    pick_valid = 1'b0;
    pick_hi    = 1'b0;
    pick_idx   = '0;
    pick_bound = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (req_i[i] && !pick_valid) begin
        pick_valid = 1'b1;
        pick_idx   = IdxW'(i);
        pick_bound = bound_i[i*BoundW +: BoundW];
      end
    end
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (req_i[i] && (i >= 32'(rr_q)) && !pick_hi) begin
        pick_hi    = 1'b1;
        pick_idx   = IdxW'(i);
        pick_bound = bound_i[i*BoundW +: BoundW];
      end
    end
  end

  // The mask fills every bit at or below the bound's MSB: the smallest 2^k-1 >= bound.
  always_comb begin
    mask = '0;
    for (int unsigned b = 0; b < BoundW; b++) begin
      mask[b] = |(bound_q >> b);
    end
  end

  assign cand      = rng_number_i[BoundW-1:0] & mask;
  assign accept    = (cand <= bound_q);
  assign exhausted = (retry_q == RetryMax);
  assign rr_next   = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEED:    state_d = LOAD;
      LOAD:    state_d = IDLE;
      IDLE:    if (pick_valid) state_d = SAMPLE;
      SAMPLE:  if (rng_valid_i && (accept || exhausted)) state_d = RESP;
      RESP:    if (rsp_ready_i[idx_q]) state_d = IDLE;
      default: state_d = SEED;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seed_q       <= 1'b0;
      ack_q        <= '0;
      bound_q      <= '0;
      idx_q        <= '0;
      rr_q         <= '0;
      retry_q      <= '0;
      rsp_number_q <= '0;
    end else begin
      // Registering the strobe places it in the first IDLE cycle, which is
      // also the cycle in which ready_o first rises.
      seed_q <= (state_q == LOAD);
      ack_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            bound_q         <= pick_bound;
            idx_q           <= pick_idx;
            ack_q[pick_idx] <= 1'b1;
            retry_q         <= '0;
          end
        end
        SAMPLE: begin
          if (rng_valid_i) begin
            if (accept) begin
              rsp_number_q <= cand;
            end else if (!exhausted) begin
              retry_q <= retry_q + 1'b1;
            end else begin
              rsp_number_q <= cand >> 1;
            end
          end
        end
        RESP: begin
          if (rsp_ready_i[idx_q]) begin
            rr_q <= rr_next;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state_q == RESP) begin
      rsp_valid_o[idx_q] = 1'b1;
    end
  end

  assign rng_load_seed_o = seed_q;
  assign req_ack_o       = ack_q;
  assign rsp_number_o    = rsp_number_q;
  assign ready_o         = (state_q == IDLE) || (state_q == SAMPLE) || (state_q == RESP);

endmodule
